// File: rtl/tcdm_pkg.sv
// Shared types and constants for the TCDM bank-port arbiter.
// arb_idx_t is sized for the default port count; blocks built for other
// port counts size their index vectors with idx_width().
package tcdm_pkg;

  localparam int TCDM_NUM_PORTS_DEFAULT = 4;

  // Width of an index able to address n entries (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TCDM_ARB_IDX_W = idx_width(TCDM_NUM_PORTS_DEFAULT);

  typedef logic [TCDM_ARB_IDX_W-1:0] arb_idx_t;

  localparam int TCDM_PERF_CNT_W = 32;

endpackage

// File: rtl/mem_intf.sv
// Single-bank TCDM memory port: request channel plus in-order read response.
interface mem_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
) ();

  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wen;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;

  modport master (
    output req, addr, wen, data, be, r_ready,
    input  gnt, r_valid, r_data
  );

  modport slave (
    input  req, addr, wen, data, be, r_ready,
    output gnt, r_valid, r_data
  );

endinterface

// File: rtl/tcdm_id_fifo.sv
// In-order FIFO of initiator indices for outstanding reads.
// Push and pop may occur together at any occupancy, including full; the
// slot being written when full is the one being vacated in the same cycle.
module tcdm_id_fifo
  import tcdm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = $bits(arb_idx_t)
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [IDX_W-1:0] head
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = idx_width(DEPTH + 1);

  logic [IDX_W-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = store[rd_ptr];

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      store[wr_ptr] <= push_idx;
    end
  end

  // Pointer and occupancy tracking; push with pop leaves occupancy unchanged.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcdm_port_arbiter.sv
// Round-robin arbiter in front of one TCDM bank.
// Grants are combinational from the bank's gnt; read responses are routed
// back through an in-order ID FIFO, also combinationally.
// Optional build macro TCDM_ARB_PERF_EN adds grant/stall performance counters;
// without it the perf outputs are tied to zero.
module tcdm_port_arbiter
  import tcdm_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 256,
  parameter int ID_FIFO_DEPTH = 2
) (
  input  logic                                      clk_i,
  input  logic                                      resetn_i,
  input  logic [NUM_PORTS-1:0]                      req_i,
  input  logic [NUM_PORTS-1:0]                      wen_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]      addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]      wdata_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]    be_i,
  output logic [NUM_PORTS-1:0]                      gnt_o,
  output logic [NUM_PORTS-1:0]                      r_valid_o,
  input  logic [NUM_PORTS-1:0]                      r_ready_i,
  output logic [DATA_WIDTH-1:0]                     r_data_o,
  mem_intf.master                                   mem,
  output logic [NUM_PORTS-1:0][TCDM_PERF_CNT_W-1:0] perf_gnt_cnt_o,
  output logic [TCDM_PERF_CNT_W-1:0]                perf_stall_cnt_o
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] head;
  logic             found;
  logic             any_req;
  logic             can_issue;
  logic             handshake;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  assign any_req = |req_i;

  // First requesting port at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // A request may issue when the FIFO has room, or room appears this cycle.
  assign can_issue = !fifo_full || fifo_pop;
  assign mem.req   = any_req && can_issue;
  assign mem.addr  = any_req ? addr_i[sel]  : '0;
  assign mem.wen   = any_req ? wen_i[sel]   : 1'b0;
  assign mem.data  = any_req ? wdata_i[sel] : '0;
  assign mem.be    = any_req ? be_i[sel]    : '0;

  assign handshake = mem.req && mem.gnt;
  assign gnt_o     = handshake ? (NUM_PORTS'(1) << sel) : '0;

  // Response side: an empty FIFO accepts (and drops) stray responses.
  assign mem.r_ready = fifo_empty ? 1'b1 : r_ready_i[head];
  assign r_valid_o   = (mem.r_valid && !fifo_empty) ? (NUM_PORTS'(1) << head) : '0;
  assign r_data_o    = mem.r_data;
  assign fifo_pop    = mem.r_valid && mem.r_ready && !fifo_empty;
  assign fifo_push   = handshake && !mem.wen;

  // Pointer moves past the granted port only on a completed handshake.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
    end
  end

  tcdm_id_fifo #(
    .DEPTH (ID_FIFO_DEPTH),
    .IDX_W (IDX_W)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .push     (fifo_push),
    .push_idx (sel),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

`ifdef TCDM_ARB_PERF_EN
  logic [NUM_PORTS-1:0][TCDM_PERF_CNT_W-1:0] gnt_cnt_q;
  logic [TCDM_PERF_CNT_W-1:0]                stall_cnt_q;

  // Free-running wrap-around counters of grants per port and stalled cycles.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      gnt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (handshake) begin
        gnt_cnt_q[sel] <= gnt_cnt_q[sel] + 1'b1;
      end
      if (any_req && !handshake) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign perf_gnt_cnt_o   = gnt_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_gnt_cnt_o   = '0;
  assign perf_stall_cnt_o = '0;
`endif

  // A response with nothing outstanding means the bank lost sync with us.
  assert property (@(posedge clk_i) disable iff (!resetn_i)
    !(mem.r_valid && fifo_empty));

endmodule

// File: tb/tb_tcdm_port_arbiter.sv
// Bench for tcdm_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a queue-based model of the arbiter and bank.
module tb_tcdm_port_arbiter;

  localparam int NP    = 4;
  localparam int AW    = 32;
  localparam int DW    = 256;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic resetn_i = 1'b0;
  logic [NP-1:0]             req_i = '0;
  logic [NP-1:0]             wen_i = '0;
  logic [NP-1:0]             r_ready_i = '0;
  logic [NP-1:0][AW-1:0]     addr_i = '0;
  logic [NP-1:0][DW-1:0]     wdata_i = '0;
  logic [NP-1:0][DW/8-1:0]   be_i = '0;
  logic [NP-1:0]             gnt_o;
  logic [NP-1:0]             r_valid_o;
  logic [DW-1:0]             r_data_o;
  logic [NP-1:0][31:0]       perf_gnt_cnt_o;
  logic [31:0]               perf_stall_cnt_o;

  mem_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  tcdm_port_arbiter #(
    .NUM_PORTS     (NP),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .ID_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i            (clk),
    .resetn_i         (resetn_i),
    .req_i            (req_i),
    .wen_i            (wen_i),
    .addr_i           (addr_i),
    .wdata_i          (wdata_i),
    .be_i             (be_i),
    .gnt_o            (gnt_o),
    .r_valid_o        (r_valid_o),
    .r_ready_i        (r_ready_i),
    .r_data_o         (r_data_o),
    .mem              (mem_if),
    .perf_gnt_cnt_o   (perf_gnt_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [AW-1:0] addr;
  } rd_t;

  rd_t           outq[$];
  int            total = 0;
  int            bad = 0;
  int            p_gnt = 0;
  int            p_rv = 0;
  int            m_rr = 0;
  logic [31:0]   m_gcnt [NP];
  logic [31:0]   m_stall = '0;
  logic [NP-1:0] last_gnt = '0;
  bit            rv_hold = 1'b0;

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return {8{a ^ 32'h1357_9BDF}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Bank model drives gnt / response; responses stay up until accepted.
  task automatic drive_bank();
    if (!resetn_i) begin
      mem_if.gnt     = 1'b0;
      mem_if.r_valid = 1'b0;
      mem_if.r_data  = '0;
    end else begin
      mem_if.gnt = ($urandom_range(99) < p_gnt);
      if (outq.size() > 0 && (rv_hold || $urandom_range(99) < p_rv)) begin
        mem_if.r_valid = 1'b1;
        mem_if.r_data  = rdata_of(outq[0].addr);
      end else begin
        mem_if.r_valid = 1'b0;
        mem_if.r_data  = {8{$urandom}};
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    drive_bank();
    #2;
  endtask

  task automatic pulse_reset();
    next_cycle();
    resetn_i = 1'b0;
    req_i    = '0;
    apply();
    next_cycle();
    resetn_i = 1'b1;
    apply();
  endtask

  // Reference model: compare every cycle, then advance by the arbiter rules.
  always @(negedge clk) begin : model
    int            sel;
    bit            found;
    bit            any;
    bit            pop;
    bit            hs;
    bit            e_rready;
    bit            e_req;
    logic [NP-1:0] e_gnt;
    logic [NP-1:0] e_rv;
    if (!resetn_i) begin
      m_rr = 0;
      outq.delete();
      rv_hold  = 1'b0;
      last_gnt = '0;
      m_stall  = '0;
      for (int p = 0; p < NP; p++) m_gcnt[p] = '0;
    end
    sel   = 0;
    found = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (!found && req_i[(m_rr + k) % NP]) begin
        found = 1'b1;
        sel   = (m_rr + k) % NP;
      end
    end
    any      = (req_i != '0);
    e_rready = (outq.size() == 0) ? 1'b1 : r_ready_i[outq[0].port];
    pop      = mem_if.r_valid && (outq.size() > 0) && e_rready;
    e_req    = any && ((outq.size() < DEPTH) || pop);
    hs       = e_req && mem_if.gnt;
    e_gnt    = hs ? (NP'(1) << sel) : '0;
    e_rv     = (mem_if.r_valid && outq.size() > 0) ? (NP'(1) << outq[0].port) : '0;

    chk("gnt_o", gnt_o, e_gnt);
    chk("r_valid_o", r_valid_o, e_rv);
    chk("mem_req", mem_if.req, e_req);
    chk("mem_r_ready", mem_if.r_ready, e_rready);
    chk("mem_addr", mem_if.addr, any ? addr_i[sel] : '0);
    chk("mem_wen", mem_if.wen, any ? wen_i[sel] : 1'b0);
    chk("mem_data", mem_if.data, any ? wdata_i[sel] : '0);
    chk("mem_be", mem_if.be, any ? be_i[sel] : '0);
    if (mem_if.r_valid && outq.size() > 0)
      chk("r_data_o", r_data_o, rdata_of(outq[0].addr));
`ifdef TCDM_ARB_PERF_EN
    for (int p = 0; p < NP; p++) chk("perf_gnt", perf_gnt_cnt_o[p], m_gcnt[p]);
    chk("perf_stall", perf_stall_cnt_o, m_stall);
`else
    for (int p = 0; p < NP; p++) chk("perf_gnt_off", perf_gnt_cnt_o[p], '0);
    chk("perf_stall_off", perf_stall_cnt_o, '0);
`endif

    if (resetn_i) begin
      if (pop) void'(outq.pop_front());
      if (hs) begin
        m_rr = (sel + 1) % NP;
        if (!wen_i[sel]) outq.push_back('{port: sel, addr: addr_i[sel]});
        m_gcnt[sel] = m_gcnt[sel] + 32'd1;
      end
      if (any && !hs) m_stall = m_stall + 32'd1;
      rv_hold  = mem_if.r_valid && !e_rready;
      last_gnt = e_gnt;
    end
  end

  initial begin : stim
    logic [NP-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;
    apply();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    apply();
    chk("rst_gnt", gnt_o, '0);
    chk("rst_rvalid", r_valid_o, '0);
    chk("rst_mem_req", mem_if.req, 1'b0);
    chk("rst_mem_addr", mem_if.addr, '0);
    next_cycle();
    resetn_i = 1'b1;
    apply();

    // Port 0 writes: 14 cycles, bank refuses on 4 of them
    for (int k = 0; k < 14; k++) begin
      next_cycle();
      req_i      = 4'b0001;
      wen_i      = 4'b0001;
      addr_i[0]  = 32'h40;
      wdata_i[0] = {32{8'hA5}};
      be_i[0]    = '1;
      r_ready_i  = '1;
      p_gnt      = (k % 3 == 2 && k < 12) ? 0 : 100;
      apply();
      if (k == 0) begin
        chk("wr_gnt", gnt_o, 4'b0001);
        chk("wr_mem_addr", mem_if.addr, 32'h40);
        chk("wr_mem_wen", mem_if.wen, 1'b1);
        chk("wr_mem_data", mem_if.data, {32{8'hA5}});
      end
      if (k == 1) chk("wr_no_rvalid", r_valid_o, '0);
    end
    next_cycle();
    req_i = '0;
    wen_i = '0;
    apply();
`ifdef TCDM_ARB_PERF_EN
    chk("perf_gnt0_lit", perf_gnt_cnt_o[0], 32'd10);
    chk("perf_stall_lit", perf_stall_cnt_o, 32'd4);
`else
    chk("perf_gnt0_lit", perf_gnt_cnt_o[0], 32'd0);
    chk("perf_stall_lit", perf_stall_cnt_o, 32'd0);
`endif

    // All four ports read continuously from rr_ptr=0
    pulse_reset();
    for (int p = 0; p < NP; p++) addr_i[p] = 32'h100 * (p + 1);
    wen_i = '0;
    p_gnt = 100;
    p_rv  = 100;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      req_i = '1;
      apply();
      chk("rr_gnt_seq", gnt_o, seq[k]);
      if (k > 0) chk("rr_rvalid_seq", r_valid_o, seq[k-1]);
      if (k == 1) chk("rr_rdata_p0", r_data_o, {8{32'h1357_9ADF}});
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req_i = '0;
      apply();
    end

    // Port 2 response back-pressured for 3 cycles while port 1 waits
    next_cycle();
    req_i     = 4'b0100;
    addr_i[2] = 32'h2000;
    p_gnt     = 100;
    apply();
    chk("bp_gnt_p2", gnt_o, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      req_i     = 4'b0010;
      addr_i[1] = 32'h1000;
      r_ready_i = 4'b1011;
      p_gnt     = 0;
      apply();
      chk("bp_hold_rvalid", r_valid_o, 4'b0100);
      chk("bp_hold_gnt", gnt_o, '0);
    end
    next_cycle();
    r_ready_i = '1;
    p_gnt     = 100;
    apply();
    chk("bp_release_gnt", gnt_o, 4'b0010);
    chk("bp_release_rvalid", r_valid_o, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req_i = '0;
      apply();
    end

    // Reset with a read outstanding
    next_cycle();
    req_i     = 4'b0001;
    addr_i[0] = 32'h3000;
    apply();
    chk("rst_pend_gnt0", gnt_o, 4'b0001);
    next_cycle();
    resetn_i = 1'b0;
    req_i    = 4'b0010;
    apply();
    chk("rst_mid_gnt", gnt_o, '0);
    chk("rst_mid_rvalid", r_valid_o, '0);
    next_cycle();
    resetn_i  = 1'b1;
    req_i     = 4'b1000;
    addr_i[3] = 32'h4000;
    apply();
    chk("post_rst_gnt3", gnt_o, 4'b1000);
    next_cycle();
    req_i = '0;
    apply();

    // Randomized traffic; requests held until granted
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if (c == 1500) resetn_i = 1'b0;
      if (c == 1503) resetn_i = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (!(req_i[p] && !last_gnt[p])) begin
          req_i[p]   = ($urandom_range(99) < 55);
          wen_i[p]   = $urandom_range(1);
          addr_i[p]  = $urandom;
          wdata_i[p] = {8{$urandom}};
          be_i[p]    = $urandom;
        end
        r_ready_i[p] = ($urandom_range(99) < 70);
      end
      p_gnt = 70;
      p_rv  = 60;
      apply();
    end

    next_cycle();
    req_i = '0;
    apply();
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
